mem_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU. It consumes the ALU result, store data, control word, instruction and destination register.
- Performs LW/SW accesses to a variable-latency data memory over a req/ack handshake. Stalls upstream while an access is outstanding.
- Forwards a single registered result bundle to writeback. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_req_fsm.sv | 45 ++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage shared definitions: control bit indices,
// LW/SW opcodes, request FSM state encoding.
package mem_stage_pkg;

  localparam int CONTROL_REG_SIZE = 8;

  localparam int I_TYPE    = 0;
  localparam int MEM_READ  = 1;
  localparam int MEM_WRITE = 2;
  localparam int REG_WRITE = 3;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_RD = 2'd1;
  localparam logic [1:0] WAIT_WR = 2'd2;

  function automatic logic [CONTROL_REG_SIZE-1:0] clr_wr(
    input logic [CONTROL_REG_SIZE-1:0] c
  );
    logic [CONTROL_REG_SIZE-1:0] r;
    r = c;
    r[REG_WRITE] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data memory request FSM: state, timeout counter, mem_req, stall.
// Ports: clock/reset, start_rd/start_wr, mem_ack -> state, mem_req, stall, ack_done, timeout_done.
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_rd,
  input  logic       start_wr,
  input  logic       mem_ack,
  output logic [1:0] state,
  output logic       mem_req,
  output logic       stall,
  output logic       ack_done,
  output logic       timeout_done
);

  logic [7:0] count;

  assign stall    = (state != IDLE);
  assign mem_req  = stall;
  assign ack_done = mem_req && mem_ack;
  // An ack on the final cycle beats the timeout.
  assign timeout_done = mem_req && !mem_ack
    && (count == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= 8'd0;
    end else if (ack_done || timeout_done) begin
      state <= IDLE;
      count <= 8'd0;
    end else if (mem_req) begin
      count <= count + 8'd1;
    end else if (start_rd) begin
      state <= WAIT_RD;
    end else if (start_wr) begin
      state <= WAIT_WR;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: LW/SW via req/ack, passthrough otherwise.
// Optional MEM_ALIGN_CHECK_EN: misaligned LW/SW retire with mem_err.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       alu_result,
  input  logic [DATA_WIDTH-1:0]       rt_data,
  input  logic [CONTROL_REG_SIZE-1:0] control,
  input  logic [31:0]                 insn,
  input  logic [4:0]                  rd_in,
  output logic                        stall,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [DATA_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       wb_data,
  output logic [4:0]                  rd_out,
  output logic [CONTROL_REG_SIZE-1:0] control_out,
  output logic [31:0]                 insn_out,
  output logic                        mem_err
);

  logic [1:0] state;
  logic accept, is_lw, is_sw, is_mem, misalign;
  logic start_rd, start_wr, ack_done, timeout_done;

  logic [DATA_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [CONTROL_REG_SIZE-1:0] ctrl_q;
  logic [31:0]                 insn_q;
  logic [4:0]                  rd_q;

  assign accept = in_valid && !stall;
  assign is_lw  = control[I_TYPE] && (insn[31:26] == OP_LW);
  assign is_sw  = control[I_TYPE] && (insn[31:26] == OP_SW);
  assign is_mem = is_lw || is_sw;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem && (alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign start_rd = accept && is_lw && !misalign;
  assign start_wr = accept && is_sw && !misalign;

  mem_req_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clock       (clock),
    .reset       (reset),
    .start_rd    (start_rd),
    .start_wr    (start_wr),
    .mem_ack     (mem_ack),
    .state       (state),
    .mem_req     (mem_req),
    .stall       (stall),
    .ack_done    (ack_done),
    .timeout_done(timeout_done)
  );

  assign mem_we    = (state == WAIT_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      insn_q      <= '0;
      rd_q        <= '0;
      out_valid   <= 1'b0;
      wb_data     <= '0;
      rd_out      <= '0;
      control_out <= '0;
      insn_out    <= '0;
      mem_err     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      mem_err   <= 1'b0;
      if (accept) begin
        addr_q  <= alu_result;
        wdata_q <= rt_data;
        ctrl_q  <= control;
        insn_q  <= insn;
        rd_q    <= rd_in;
        if (!is_mem || misalign) begin
          out_valid   <= 1'b1;
          rd_out      <= rd_in;
          insn_out    <= insn;
          mem_err     <= misalign;
          wb_data     <= misalign ? '0 : alu_result;
          control_out <= misalign ? clr_wr(control) : control;
        end
      end
      if (ack_done) begin
        out_valid   <= 1'b1;
        rd_out      <= rd_q;
        insn_out    <= insn_q;
        if (state == WAIT_RD) begin
          wb_data     <= mem_rdata;
          control_out <= ctrl_q;
        end else begin
          wb_data     <= addr_q;
          control_out <= clr_wr(ctrl_q);
        end
      end
      // A timed-out access must not write a bogus zero to the register file.
      if (timeout_done) begin
        out_valid   <= 1'b1;
        mem_err     <= 1'b1;
        wb_data     <= '0;
        rd_out      <= rd_q;
        insn_out    <= insn_q;
        control_out <= clr_wr(ctrl_q);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (TIMEOUT_CYCLES=4).
// Directed LW/SW/ALU vectors; monitor compares each retire.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [31:0] insn;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] rt_data = '0;
  logic [7:0]  control = '0;
  logic [31:0] insn = '0;
  logic [4:0]  rd_in = '0;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic [31:0] wb_data;
  logic [4:0]  rd_out;
  logic [7:0]  control_out;
  logic [31:0] insn_out;
  logic        mem_err;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  localparam logic [7:0] C_ALU = 8'h08;
  localparam logic [7:0] C_LW  = 8'h0B;
  localparam logic [7:0] C_SW  = 8'h0D;
  localparam logic [31:0] I_ADDU = 32'h0043_0821;
  localparam logic [31:0] I_LW   = 32'h8C02_0100;
  localparam logic [31:0] I_SW   = 32'hAC02_0200;

  mem_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .alu_result(alu_result), .rt_data(rt_data),
    .control(control), .insn(insn), .rd_in(rd_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .wb_data(wb_data), .rd_out(rd_out),
    .control_out(control_out), .insn_out(insn_out),
    .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] d,
                       logic [7:0] c, logic [31:0] i,
                       logic [4:0] r);
    alu_result = a; rt_data = d; control = c; insn = i; rd_in = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push(logic [31:0] d, logic [4:0] r,
                      logic [7:0] c, logic [31:0] i, logic e);
    exp_t x;
    x.data = d; x.rd = r; x.ctrl = c; x.insn = i; x.err = e;
    q.push_back(x);
  endtask

  // Ack on the k-th request cycle; returns count of req/stall cycles seen.
  task automatic wait_ack(int k, logic [31:0] rdata,
                          output int reqs, output int stalls);
    reqs = 0; stalls = 0;
    for (int c = 1; c <= k; c++) begin
      if (mem_req) reqs++;
      if (stall) stalls++;
      if (c == k) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      tick();
    end
    mem_ack = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_retire: got wb %h want none", wb_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_total++;
        if (wb_data === e.data && rd_out === e.rd
            && control_out === e.ctrl && insn_out === e.insn
            && mem_err === e.err) n_pass++;
        else $display("FAIL retire: got %h/%0d/%h/%h/%b want %h/%0d/%h/%h/%b",
          wb_data, rd_out, control_out, insn_out, mem_err,
          e.data, e.rd, e.ctrl, e.insn, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int reqs, stalls;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    // ALU passthrough
    push(32'h10, 5'd1, C_ALU, I_ADDU, 1'b0);
    issue(32'h10, 32'h0, C_ALU, I_ADDU, 5'd1);
    chk("addu_stall", 32'(stall), 32'd0);
    chk("addu_valid", 32'(out_valid), 32'd1);
    tick();

    // LW, ack on third req cycle
    push(32'hDEADBEEF, 5'd2, C_LW, I_LW, 1'b0);
    issue(32'h100, 32'h0, C_LW, I_LW, 5'd2);
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_we", 32'(mem_we), 32'd0);
    chk("lw_bubble", 32'(out_valid), 32'd0);
    wait_ack(3, 32'hDEADBEEF, reqs, stalls);
    chk("lw_req_cycles", 32'(reqs), 32'd3);
    chk("lw_stall_cycles", 32'(stalls), 32'd3);
    chk("lw_valid", 32'(out_valid), 32'd1);
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    // back-to-back ALU right after the load retires
    push(32'h55, 5'd7, C_ALU, I_ADDU, 1'b0);
    issue(32'h55, 32'h0, C_ALU, I_ADDU, 5'd7);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    tick();

    // SW, ack on first req cycle: 2-cycle latency, reg-write cleared
    push(32'h200, 5'd3, 8'h05, I_SW, 1'b0);
    issue(32'h200, 32'h1234, C_SW, I_SW, 5'd3);
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_wdata", mem_wdata, 32'h1234);
    wait_ack(1, 32'hFFFF_FFFF, reqs, stalls);
    chk("sw_req_cycles", 32'(reqs), 32'd1);
    chk("sw_valid", 32'(out_valid), 32'd1);
    tick();

    // LW timeout, then a late ack is ignored
    push(32'h0, 5'd4, 8'h03, I_LW, 1'b1);
    issue(32'h104, 32'h0, C_LW, I_LW, 5'd4);
    reqs = 0;
    while (mem_req && reqs < 10) begin
      reqs++;
      tick();
    end
    chk("to_req_cycles", 32'(reqs), 32'd4);
    chk("to_valid", 32'(out_valid), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_valid", 32'(out_valid), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    tick();

    // ack on the timeout cycle wins
    push(32'hCAFE_F00D, 5'd5, C_LW, I_LW, 1'b0);
    issue(32'h108, 32'h0, C_LW, I_LW, 5'd5);
    wait_ack(4, 32'hCAFE_F00D, reqs, stalls);
    chk("edge_req_cycles", 32'(reqs), 32'd4);
    chk("edge_valid", 32'(out_valid), 32'd1);
    tick();

    // reset mid-access discards the load
    issue(32'h10C, 32'h0, C_LW, I_LW, 5'd6);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    push(32'h77, 5'd8, C_ALU, I_ADDU, 1'b0);
    issue(32'h77, 32'h0, C_ALU, I_ADDU, 5'd8);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    push(32'h0, 5'd9, 8'h03, I_LW, 1'b1);
    issue(32'h102, 32'h0, C_LW, I_LW, 5'd9);
    chk("align_req", 32'(mem_req), 32'd0);
    chk("align_stall", 32'(stall), 32'd0);
    chk("align_valid", 32'(out_valid), 32'd1);
    tick();
`else
    // without the check, low address bits pass straight through
    push(32'h0BAD_0001, 5'd9, C_LW, I_LW, 1'b0);
    issue(32'h102, 32'h0, C_LW, I_LW, 5'd9);
    chk("noalign_addr", mem_addr, 32'h102);
    wait_ack(1, 32'h0BAD_0001, reqs, stalls);
    tick();
`endif

    tick(); tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
